conv_mdc_ctrl_fsm: RTL and testbench

// - Job sequencer for the conv_mdc accelerator; sits between the register-file slave and the conv_mdc engine/streamers.
// - Feeds the engine control channel (start, clear, width, height) and arms the source/sink streamers.
// - Consumes the engine flags (done, ready, output count) and streamer flags, then raises one job-done event.
// - Watchdog flags jobs that stall with no output progress.

---
 rtl/conv_mdc_ctrl_fsm_pkg.sv | 27 ++
 rtl/conv_mdc_ctrl_fsm_watchdog.sv | 42 ++++
 rtl/conv_mdc_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_conv_mdc_ctrl_fsm.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mdc_ctrl_fsm_pkg.sv
// Shared types and constants for the conv_mdc job sequencer.
package conv_mdc_package;

  localparam int CONV_MDC_DIM_W     = 16;
  localparam int CONV_MDC_CNT_W     = 32;
  localparam int CONV_MDC_TIMEOUT_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ARM,
    RUN,
    FINISH
  } ctrl_fsm_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ZERO_DIM = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } ctrl_fsm_err_t;

  // A job is only launched when both image dimensions are non-zero.
  function automatic logic dims_nonzero(input logic any_w_bit, input logic any_h_bit);
    return any_w_bit & any_h_bit;
  endfunction

endpackage

// File: rtl/conv_mdc_ctrl_fsm_watchdog.sv
// Stall watchdog: counts cycles without progress, expires at all-ones.
module conv_mdc_watchdog
  import conv_mdc_package::*;
#(
  parameter int TIMEOUT_W = CONV_MDC_TIMEOUT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic reload_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;
  logic                 at_max;

  assign at_max    = &cnt_q;
  assign expired_o = en_i & at_max;

  // Next count: held at zero while disabled, reloaded on progress, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (reload_i) begin
      cnt_d = '0;
    end else if (!at_max) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_mdc_ctrl_fsm.sv
// Job sequencer between the register-file slave and the conv_mdc engine/streamers.
// Every output except the width/height latch is a flop computed from the
// next-state decision, so each status appears in the cycle its state is held.
module conv_mdc_ctrl_fsm
  import conv_mdc_package::*;
#(
  parameter int DIM_W     = CONV_MDC_DIM_W,
  parameter int CNT_W     = CONV_MDC_CNT_W,
  parameter int TIMEOUT_W = CONV_MDC_TIMEOUT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             cfg_start_i,
  input  logic [DIM_W-1:0] cfg_width_i,
  input  logic [DIM_W-1:0] cfg_height_i,
  output logic             eng_start_o,
  output logic             eng_clear_o,
  output logic [DIM_W-1:0] eng_width_o,
  output logic [DIM_W-1:0] eng_height_o,
  input  logic             eng_ready_i,
  input  logic             eng_done_i,
  input  logic [CNT_W-1:0] eng_cnt_i,
  output logic             src_req_o,
  input  logic             src_ack_i,
  output logic             snk_req_o,
  input  logic             snk_ack_i,
  input  logic             snk_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o,
  output logic [CNT_W-1:0] words_o
);

  ctrl_fsm_state_t state_q, state_d;
  ctrl_fsm_err_t   err_q, err_d;

  logic [DIM_W-1:0] width_q, width_d;
  logic [DIM_W-1:0] height_q, height_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] cnt_prev_q, cnt_prev_d;

  logic src_req_q, src_req_d;
  logic snk_req_q, snk_req_d;
  logic src_seen_q, src_seen_d;
  logic snk_seen_q, snk_seen_d;
  logic eng_done_seen_q, eng_done_seen_d;
  logic snk_done_seen_q, snk_done_seen_d;
  logic eng_start_q, eng_start_d;
  logic eng_clear_q, eng_clear_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic src_hit;
  logic snk_hit;
  logic wd_en;
  logic wd_reload;
  logic wd_expired;

  // An ack only counts while its request is still outstanding.
  assign src_hit = src_req_q & src_ack_i;
  assign snk_hit = snk_req_q & snk_ack_i;

  // Watchdog is live only while the job depends on external progress.
  assign wd_en     = ((state_q == ARM) || (state_q == RUN)) && !clear_i;
  assign wd_reload = src_ack_i | snk_ack_i | snk_done_i | (eng_cnt_i != cnt_prev_q);

  conv_mdc_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (wd_en),
    .reload_i (wd_reload),
    .expired_o(wd_expired)
  );

  // Next-state and registered-output decisions; timeout and clear override the normal flow.
  always_comb begin
    state_d         = state_q;
    err_d           = err_q;
    width_d         = width_q;
    height_d        = height_q;
    words_d         = words_q;
    cnt_prev_d      = eng_cnt_i;
    src_req_d       = src_req_q;
    snk_req_d       = snk_req_q;
    src_seen_d      = src_seen_q;
    snk_seen_d      = snk_seen_q;
    eng_done_seen_d = eng_done_seen_q;
    snk_done_seen_d = snk_done_seen_q;
    eng_start_d     = 1'b0;
    eng_clear_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          width_d  = cfg_width_i;
          height_d = cfg_height_i;
          state_d  = CHECK;
          // Engine clear is shown during CHECK, but only for a job that will actually run.
          eng_clear_d = dims_nonzero(|cfg_width_i, |cfg_height_i);
        end
      end
      CHECK: begin
        if (!dims_nonzero(|width_q, |height_q)) begin
          err_d   = ERR_ZERO_DIM;
          state_d = FINISH;
        end else begin
          err_d           = ERR_NONE;
          state_d         = ARM;
          src_req_d       = 1'b1;
          snk_req_d       = 1'b1;
          src_seen_d      = 1'b0;
          snk_seen_d      = 1'b0;
          eng_done_seen_d = 1'b0;
          snk_done_seen_d = 1'b0;
        end
      end
      ARM: begin
        if (src_hit) begin
          src_req_d  = 1'b0;
          src_seen_d = 1'b1;
        end
        if (snk_hit) begin
          snk_req_d  = 1'b0;
          snk_seen_d = 1'b1;
        end
        if ((src_seen_q | src_hit) && (snk_seen_q | snk_hit) && eng_ready_i) begin
          eng_start_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        eng_done_seen_d = eng_done_seen_q | eng_done_i;
        snk_done_seen_d = snk_done_seen_q | snk_done_i;
        if ((eng_done_seen_q | eng_done_i) && (snk_done_seen_q | snk_done_i)) begin
          words_d = eng_cnt_i;
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wd_expired) begin
      err_d       = ERR_TIMEOUT;
      eng_clear_d = 1'b1;
      eng_start_d = 1'b0;
      src_req_d   = 1'b0;
      snk_req_d   = 1'b0;
      state_d     = FINISH;
    end

    // Soft clear wins over everything, including a coincident start.
    if (clear_i) begin
      state_d         = IDLE;
      err_d           = ERR_NONE;
      width_d         = width_q;
      height_d        = height_q;
      words_d         = words_q;
      src_req_d       = 1'b0;
      snk_req_d       = 1'b0;
      src_seen_d      = 1'b0;
      snk_seen_d      = 1'b0;
      eng_done_seen_d = 1'b0;
      snk_done_seen_d = 1'b0;
      eng_start_d     = 1'b0;
      eng_clear_d     = 1'b1;
    end

    done_d = (state_d == FINISH);
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      err_q           <= ERR_NONE;
      width_q         <= '0;
      height_q        <= '0;
      words_q         <= '0;
      cnt_prev_q      <= '0;
      src_req_q       <= 1'b0;
      snk_req_q       <= 1'b0;
      src_seen_q      <= 1'b0;
      snk_seen_q      <= 1'b0;
      eng_done_seen_q <= 1'b0;
      snk_done_seen_q <= 1'b0;
      eng_start_q     <= 1'b0;
      eng_clear_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      err_q           <= err_d;
      width_q         <= width_d;
      height_q        <= height_d;
      words_q         <= words_d;
      cnt_prev_q      <= cnt_prev_d;
      src_req_q       <= src_req_d;
      snk_req_q       <= snk_req_d;
      src_seen_q      <= src_seen_d;
      snk_seen_q      <= snk_seen_d;
      eng_done_seen_q <= eng_done_seen_d;
      snk_done_seen_q <= snk_done_seen_d;
      eng_start_q     <= eng_start_d;
      eng_clear_q     <= eng_clear_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign eng_start_o  = eng_start_q;
  assign eng_clear_o  = eng_clear_q;
  assign eng_width_o  = width_q;
  assign eng_height_o = height_q;
  assign src_req_o    = src_req_q;
  assign snk_req_o    = snk_req_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_o      = words_q;

endmodule

// File: tb/tb_conv_mdc_ctrl_fsm.sv
// Directed bench for conv_mdc_ctrl_fsm (watchdog shortened to 4 bits).
module tb_conv_mdc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_width = '0;
  logic [15:0] cfg_height = '0;
  logic        eng_start;
  logic        eng_clear;
  logic [15:0] eng_width;
  logic [15:0] eng_height;
  logic        eng_ready = 1'b0;
  logic        eng_done = 1'b0;
  logic [31:0] eng_cnt = '0;
  logic        src_req;
  logic        src_ack = 1'b0;
  logic        snk_req;
  logic        snk_ack = 1'b0;
  logic        snk_done = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] words;

  int vectors = 0;
  int miscompares = 0;
  int start_pulses = 0;
  int done_pulses = 0;
  int req_cycles = 0;
  int base_start;
  int base_done;
  int base_req;

  conv_mdc_ctrl_fsm #(
    .DIM_W(16),
    .CNT_W(32),
    .TIMEOUT_W(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .cfg_start_i (cfg_start),
    .cfg_width_i (cfg_width),
    .cfg_height_i(cfg_height),
    .eng_start_o (eng_start),
    .eng_clear_o (eng_clear),
    .eng_width_o (eng_width),
    .eng_height_o(eng_height),
    .eng_ready_i (eng_ready),
    .eng_done_i  (eng_done),
    .eng_cnt_i   (eng_cnt),
    .src_req_o   (src_req),
    .src_ack_i   (src_ack),
    .snk_req_o   (snk_req),
    .snk_ack_i   (snk_ack),
    .snk_done_i  (snk_done),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .words_o     (words)
  );

  always #5 clk = ~clk;

  // Pulse/level counters sampled mid-cycle.
  always @(negedge clk) begin
    if (eng_start) start_pulses++;
    if (done) done_pulses++;
    if (src_req || snk_req) req_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    $display("vector %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_start = start_pulses;
    base_done  = done_pulses;
    base_req   = req_cycles;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_reqs", 64'({src_req, snk_req, eng_start, eng_clear}), 64'd0);
    check("rst_words", 64'(words), 64'd0);
    rst_n = 1'b1;
    tick();

    // Nominal 4x3 job
    snap();
    eng_ready = 1'b1;
    cfg_width = 16'd4; cfg_height = 16'd3; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("nom_check_clear", 64'(eng_clear), 64'd1);
    check("nom_busy", 64'(busy), 64'd1);
    check("nom_dims", 64'({eng_width, eng_height}), 64'h0004_0003);
    tick();
    check("nom_arm_reqs", 64'({src_req, snk_req, eng_clear}), 64'b110);
    tick();
    src_ack = 1'b1; snk_ack = 1'b1;
    tick();
    src_ack = 1'b0; snk_ack = 1'b0;
    check("nom_start", 64'({eng_start, src_req, snk_req}), 64'b100);
    tick();
    check("nom_start_pulse", 64'(eng_start), 64'd0);
    eng_done = 1'b1; eng_cnt = 32'd12;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("nom_wait_done", 64'(done), 64'd0);
    snk_done = 1'b1;
    tick();
    snk_done = 1'b0;
    check("nom_done", 64'(done), 64'd1);
    check("nom_words", 64'(words), 64'd12);
    check("nom_err", 64'(err), 64'd0);
    tick();
    check("nom_idle", 64'({busy, done}), 64'd0);
    check("nom_start_count", 64'(start_pulses - base_start), 64'd1);
    check("nom_done_count", 64'(done_pulses - base_done), 64'd1);

    // Zero dimension
    snap();
    cfg_width = 16'd0; cfg_height = 16'd7; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("zd_no_clear", 64'(eng_clear), 64'd0);
    check("zd_not_done_yet", 64'(done), 64'd0);
    tick();
    check("zd_done", 64'(done), 64'd1);
    check("zd_err", 64'(err), 64'd1);
    tick();
    check("zd_idle", 64'({busy, done}), 64'd0);
    check("zd_err_sticky", 64'(err), 64'd1);
    check("zd_no_req", 64'(req_cycles - base_req), 64'd0);
    check("zd_no_start", 64'(start_pulses - base_start), 64'd0);

    // Ack ordering: snk first, then src, engine not ready
    snap();
    eng_ready = 1'b0;
    cfg_width = 16'd2; cfg_height = 16'd2; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    check("ord_err_cleared", 64'(err), 64'd0);
    check("ord_reqs", 64'({src_req, snk_req}), 64'b11);
    snk_ack = 1'b1;
    tick();
    snk_ack = 1'b0;
    check("ord_snk_dropped", 64'({src_req, snk_req, eng_start}), 64'b100);
    src_ack = 1'b1;
    tick();
    src_ack = 1'b0;
    check("ord_src_dropped", 64'({src_req, snk_req, eng_start}), 64'b000);
    tick();
    check("ord_wait_ready", 64'(eng_start), 64'd0);
    eng_ready = 1'b1;
    tick();
    check("ord_start", 64'(eng_start), 64'd1);
    eng_done = 1'b1; eng_cnt = 32'd4;
    tick();
    eng_done = 1'b0; snk_done = 1'b1;
    tick();
    snk_done = 1'b0;
    check("ord_done", 64'({done, err}), 64'b100);
    check("ord_words", 64'(words), 64'd4);
    tick();
    check("ord_one_start", 64'(start_pulses - base_start), 64'd1);

    // Both acks together, ready low 3 cycles, simultaneous done
    snap();
    eng_ready = 1'b0;
    cfg_width = 16'd3; cfg_height = 16'd1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    src_ack = 1'b1; snk_ack = 1'b1;
    tick();
    src_ack = 1'b0; snk_ack = 1'b0;
    check("both_ack_reqs", 64'({src_req, snk_req, eng_start}), 64'b000);
    tick();
    tick();
    check("both_ready_low", 64'(eng_start), 64'd0);
    eng_ready = 1'b1;
    tick();
    check("both_start", 64'(eng_start), 64'd1);
    eng_done = 1'b1; snk_done = 1'b1; eng_cnt = 32'd3;
    tick();
    eng_done = 1'b0; snk_done = 1'b0;
    check("sim_done", 64'(done), 64'd1);
    check("sim_words", 64'(words), 64'd3);
    tick();
    check("sim_idle", 64'({busy, done}), 64'd0);
    check("sim_single_done", 64'(done_pulses - base_done), 64'd1);

    // Timeout: snk_done never arrives
    snap();
    cfg_width = 16'd5; cfg_height = 16'd5; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    src_ack = 1'b1; snk_ack = 1'b1;
    tick();
    src_ack = 1'b0; snk_ack = 1'b0;
    check("to_start", 64'(eng_start), 64'd1);
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", 64'({done, busy, err}), 64'b0100);
    tick();
    check("to_done", 64'(done), 64'd1);
    check("to_err", 64'(err), 64'd2);
    check("to_clear", 64'(eng_clear), 64'd1);
    tick();
    check("to_idle", 64'({busy, done, eng_clear, err}), 64'b00010);

    // Clear in RUN
    snap();
    cfg_width = 16'd2; cfg_height = 16'd2; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    src_ack = 1'b1; snk_ack = 1'b1;
    tick();
    src_ack = 1'b0; snk_ack = 1'b0;
    tick();
    check("clr_running", 64'(busy), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_idle", 64'({busy, done, eng_clear, err}), 64'b00100);
    tick();
    check("clr_no_done", 64'(done_pulses - base_done), 64'd0);

    // Start coincident with clear is dropped
    cfg_width = 16'd9; cfg_height = 16'd9; cfg_start = 1'b1; clear = 1'b1;
    tick();
    cfg_start = 1'b0; clear = 1'b0;
    check("clr_start_dropped", 64'({busy, eng_clear}), 64'b01);
    tick();
    check("clr_start_still_idle", 64'(busy), 64'd0);
    check("clr_dims_kept", 64'(eng_width), 64'd2);

    // Async reset mid-ARM
    eng_ready = 1'b0;
    cfg_width = 16'd3; cfg_height = 16'd3; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    check("rarm_req", 64'(src_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rarm_outputs", 64'({src_req, snk_req, busy, done, eng_start, eng_clear, err}), 64'd0);
    check("rarm_dims", 64'({eng_width, eng_height}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rarm_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
